reg_share_arbiter: RTL

REG_SHARE_ARBITER -- requirements
Module: reg_share_arbiter

---
 rtl/reg_share_arbiter_pkg.sv | 19 +
 rtl/rr_arbiter.sv | 35 +++
 rtl/reg_share_arbiter.sv | 132 +++++++++++++
 3 files changed

// File: rtl/reg_share_arbiter_pkg.sv
// Shared definitions for the register-sharing arbiter.
//   state_e    : FSM states of the arbiter (IDLE, GRANT, HOLD)
//   HOLD_CNT_W : width of the post-write lock-out down-counter (HOLD_CYCLES <= 15)
//   idx_w()    : width of a requester index for a given requester count
package reg_share_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    HOLD  = 2'd2
  } state_e;

  localparam int HOLD_CNT_W = 4;

  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector.
//   req     : request vector, one bit per requester
//   ptr     : index where the search starts (wraps modulo N_REQ)
//   winner  : first requester with its bit set at or after ptr
//   any_req : high when at least one request bit is set
module rr_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int IDX_W = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] winner,
  output logic             any_req
);

  logic [IDX_W-1:0] idx;

  // Scan N_REQ positions starting at ptr; the first hit is kept because
  // any_req masks every later candidate.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    idx     = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = IDX_W'((int'(ptr) + k) % N_REQ);
      if (!any_req && req[idx]) begin
        winner  = idx;
        any_req = 1'b1;
      end
    end
  end

endmodule

// File: rtl/reg_share_arbiter.sv
// Shares one WIDTH-bit register between N_REQ writers using round-robin
// arbitration, with a HOLD_CYCLES lock-out after every write.
//   clk_i        : clock, rising edge
//   rst_i        : asynchronous active-high reset
//   req_valid_i  : per-requester write request
//   req_data_i   : per-requester write data
//   req_ready_o  : per-requester accept (at most one bit high, only in GRANT)
//   data_o       : shared register contents
//   owner_o      : index of the last successful writer
//   data_valid_o : high once any write has completed since reset
//   busy_o       : high whenever the FSM is not IDLE
module reg_share_arbiter
  import reg_share_arbiter_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int WIDTH       = 8,
  parameter int HOLD_CYCLES = 2
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic [N_REQ-1:0]            req_valid_i,
  input  logic [N_REQ-1:0][WIDTH-1:0] req_data_i,
  output logic [N_REQ-1:0]            req_ready_o,
  output logic [WIDTH-1:0]            data_o,
  output logic [idx_w(N_REQ)-1:0]     owner_o,
  output logic                        data_valid_o,
  output logic                        busy_o
);

  localparam int IDX_W = idx_w(N_REQ);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(HOLD_CYCLES);

  state_e                  state;
  state_e                  nxt;
  logic [IDX_W-1:0]        rr_ptr;
  logic [IDX_W-1:0]        winner_q;
  logic [IDX_W-1:0]        arb_winner;
  logic                    arb_any;
  logic [HOLD_CNT_W-1:0]   hold_cnt;
  logic                    xfer;
  logic [N_REQ-1:0]        ready;

  rr_arbiter #(
    .N_REQ (N_REQ),
    .IDX_W (IDX_W)
  ) u_rr (
    .req     (req_valid_i),
    .ptr     (rr_ptr),
    .winner  (arb_winner),
    .any_req (arb_any)
  );

  // State register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state <= IDLE;
    end else begin
      state <= nxt;
    end
  end

  // Next state and handshake. Only the latched winner may see ready, and
  // only while it is still requesting; a withdrawn request falls back to IDLE.
  always_comb begin
    nxt   = state;
    ready = '0;
    xfer  = 1'b0;
    case (state)
      IDLE: begin
        if (arb_any) begin
          nxt = GRANT;
        end
      end
      GRANT: begin
        ready[winner_q] = req_valid_i[winner_q];
        if (req_valid_i[winner_q]) begin
          xfer = 1'b1;
          nxt  = (HOLD_CYCLES > 0) ? HOLD : IDLE;
        end else begin
          nxt = IDLE;
        end
      end
      HOLD: begin
        if (hold_cnt <= HOLD_CNT_W'(1)) begin
          nxt = IDLE;
        end
      end
      default: nxt = IDLE;
    endcase
  end

  assign req_ready_o = ready;
  assign busy_o      = (state != IDLE);

  // Winner latch, pointer and lock-out counter. The counter is loaded on the
  // GRANT->HOLD transition and HOLD leaves when it would reach zero, so HOLD
  // spans exactly HOLD_CYCLES cycles.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      winner_q <= '0;
      rr_ptr   <= '0;
      hold_cnt <= '0;
    end else begin
      if (state == IDLE && arb_any) begin
        winner_q <= arb_winner;
      end
      if (xfer) begin
        rr_ptr <= (winner_q == IDX_W'(N_REQ - 1)) ? '0 : winner_q + 1'b1;
      end
      if (state == GRANT && nxt == HOLD) begin
        hold_cnt <= HOLD_LOAD;
      end else if (state == HOLD && hold_cnt != '0) begin
        hold_cnt <= hold_cnt - 1'b1;
      end
    end
  end

  // Shared register: only a completed handshake updates it, so a reset in
  // GRANT or HOLD can never leave a partial write behind.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      data_o       <= '0;
      owner_o      <= '0;
      data_valid_o <= 1'b0;
    end else if (xfer) begin
      data_o       <= req_data_i[winner_q];
      owner_o      <= winner_q;
      data_valid_o <= 1'b1;
    end
  end

endmodule
